// File: rtl/mem_wb_pipe_pkg.sv
// ============================================================================
// mem_wb_pipe_pkg : shared defaults and bundle sizing for the MEM->WB stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_wb_pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 32;

  // Bundle is {[hilo_write, hi, lo,] rd_write, rd_addr, write_data}
  function automatic int unsigned bundle_w(input int unsigned data_w,
                                           input int unsigned addr_w,
                                           input bit          hilo);
    return data_w + addr_w + 1 + (hilo ? (2 * data_w + 1) : 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_pipe_skid_buf.sv
// ============================================================================
// pipe_skid_buf : generic W-bit two-entry valid/ready skid buffer with flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         accept;
  logic         drain;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid & ~skid_valid_q;
  assign drain     = main_valid_q & out_ready;

  // Skid is only ever occupied while main is occupied, so main-empty implies skid-empty.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end
    end else if (drain) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = accept;
        if (accept) skid_data_d = in_data;
      end else begin
        main_valid_d = accept;
        if (accept) main_data_d = in_data;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe.sv
// ============================================================================
// mem_wb_pipe : MEM->WB pipeline register with skid, flush and retire counter
// Optional HI/LO carriage enabled by defining MEMWB_HILO_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_write_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] write_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_write_o,
`ifdef MEMWB_HILO_EN
  input  logic              hilo_write_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic              hilo_write_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
`endif
  output logic [CNT_W-1:0]  retired_cnt
);

`ifdef MEMWB_HILO_EN
  localparam bit HILO_EN = 1'b1;
`else
  localparam bit HILO_EN = 1'b0;
`endif
  localparam int unsigned BW = bundle_w(DATA_W, ADDR_W, HILO_EN);

  logic [BW-1:0]    in_bundle;
  logic [BW-1:0]    out_bundle;
  logic             held_rd_write;
  logic             drain;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

`ifdef MEMWB_HILO_EN
  logic held_hilo_write;
  assign in_bundle = {hilo_write_i, hi_i, lo_i, rd_write_i, rd_addr_i, write_data_i};
  assign {held_hilo_write, hi_o, lo_o, held_rd_write, rd_addr_o, write_data_o} = out_bundle;
  assign hilo_write_o = out_valid & held_hilo_write;
`else
  assign in_bundle = {rd_write_i, rd_addr_i, write_data_i};
  assign {held_rd_write, rd_addr_o, write_data_o} = out_bundle;
`endif

  pipe_skid_buf #(
    .W (BW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bundle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bundle)
  );

  // r0 is hardwired zero: suppress the regfile write but still retire the bundle.
  assign rd_write_o = out_valid & held_rd_write & (rd_addr_o != '0);
  assign drain      = out_valid & out_ready;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (drain) retired_cnt_d = retired_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_cnt_q <= '0;
    else     retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;

endmodule

`default_nettype wire
